// File: rtl/spram_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the wait-state SRAM.
// slave = arbiter view, master = environment view (requesters plus memory).
interface spram_arb_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          m_ce, m_we, m_oe;
  logic [AW-1:0] m_addr_w, m_addr_r;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_valid;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata, m_valid,
    output ack0, ack1, rvalid0, rvalid1, rdata,
    output m_ce, m_we, m_oe, m_addr_w, m_addr_r, m_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata, m_valid,
    input  ack0, ack1, rvalid0, rvalid1, rdata,
    input  m_ce, m_we, m_oe, m_addr_w, m_addr_r, m_wdata
  );
endinterface

// File: rtl/spram_arb.sv
// Two-requester round-robin arbiter/sequencer for a stall-capable single-port SRAM.
// Optional WAIT-cycle statistics counters enabled by defining SPRAM_ARB_STAT_EN.
module spram_arb #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  spram_arb_if.slave  bus
`ifdef SPRAM_ARB_STAT_EN
  ,
  output logic [15:0] stall_cnt0,
  output logic [15:0] stall_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        r_state;
  logic          r_win, r_we, r_rr, r_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [3:0]    r_burst;
  logic          r_ack0, r_ack1, r_rvalid0, r_rvalid1;
  logic          r_m_ce, r_m_we, r_m_oe;

  logic          w_req0, w_req1, w_win, w_we, w_done;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [3:0]    w_burst;

  // A read is acked in the IDLE cycle that follows it, while the requester
  // still holds req; masking stops that same request being granted twice.
  assign w_req0 = bus.req0 & ~r_ack0;
  assign w_req1 = bus.req1 & ~r_ack1;

  always_comb begin
    w_win = w_req1;
    if (w_req0 && w_req1)
      w_win = (r_burst == 4'(MAX_BURST)) ? ~r_last : r_rr;
  end

  assign w_we    = w_win ? bus.we1    : bus.we0;
  assign w_addr  = w_win ? bus.addr1  : bus.addr0;
  assign w_wdata = w_win ? bus.wdata1 : bus.wdata0;
  assign w_burst = (w_win != r_last)             ? 4'd1 :
                   (r_burst == 4'(MAX_BURST))    ? r_burst : r_burst + 4'd1;
  assign w_done  = bus.m_valid &&
                   ((r_state == S_ISSUE && !r_we) || r_state == S_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_rr      <= 1'b0;
      r_last    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_burst   <= 4'd0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_m_ce    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_oe    <= 1'b0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req0 || w_req1) begin
            r_win   <= w_win;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rr    <= ~w_win;
            r_last  <= w_win;
            r_burst <= w_burst;
            r_m_ce  <= 1'b1;
            r_m_we  <= w_we;
            r_m_oe  <= ~w_we;
            // Writes are acknowledged in the ISSUE cycle itself.
            r_ack0  <= w_we & ~w_win;
            r_ack1  <= w_we & w_win;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_we || bus.m_valid) begin
            r_m_ce  <= 1'b0;
            r_m_we  <= 1'b0;
            r_m_oe  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.m_valid) begin
            r_m_ce  <= 1'b0;
            r_m_oe  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_done) begin
        r_rdata   <= bus.m_rdata;
        r_ack0    <= ~r_win;
        r_ack1    <= r_win;
        r_rvalid0 <= ~r_win;
        r_rvalid1 <= r_win;
      end
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
  assign bus.rdata    = r_rdata;
  assign bus.m_ce     = r_m_ce;
  assign bus.m_we     = r_m_we;
  assign bus.m_oe     = r_m_oe;
  assign bus.m_addr_w = r_addr;
  assign bus.m_addr_r = r_addr;
  assign bus.m_wdata  = r_wdata;

`ifdef SPRAM_ARB_STAT_EN
  logic [15:0] r_stall0, r_stall1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall0 <= 16'd0;
      r_stall1 <= 16'd0;
    end else if (r_state == S_WAIT) begin
      if (r_win && r_stall1 != 16'hFFFF)
        r_stall1 <= r_stall1 + 16'd1;
      else if (!r_win && r_stall0 != 16'hFFFF)
        r_stall0 <= r_stall0 + 16'd1;
    end
  end

  assign stall_cnt0 = r_stall0;
  assign stall_cnt1 = r_stall1;
`endif

endmodule

// File: tb/tb_spram_arb.sv
// Self-checking bench for spram_arb: transaction table with scoreboarded reads,
// plus fairness, burst, stall and mid-access reset sequences.
module tb_spram_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spram_arb_if #(.DW(8), .AW(8)) bus ();

`ifdef SPRAM_ARB_STAT_EN
  logic [15:0] stall_cnt0, stall_cnt1;
`endif

  spram_arb #(.DW(8), .AW(8), .MAX_BURST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPRAM_ARB_STAT_EN
    ,
    .stall_cnt0 (stall_cnt0),
    .stall_cnt1 (stall_cnt1)
`endif
  );

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  assign bus.m_rdata = mem[bus.m_addr_r];

  typedef struct {
    bit         r;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         k;
  } txn_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         stall_left = 0;
  int         exp_stall0 = 0;
  int         exp_stall1 = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         grant_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, model memory, run the scoreboard.
  task automatic tick();
    @(negedge clk);
    if (bus.m_ce && bus.m_we) mem[bus.m_addr_w] = bus.m_wdata;
    if (bus.m_ce && bus.m_oe) begin
      bus.m_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
    if (bus.ack0 || bus.ack1) chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 0);
    if (bus.ack0) grant_log.push_back(0);
    if (bus.ack1) grant_log.push_back(1);
    if (bus.rvalid0 || bus.rvalid1) chk("rvalid_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 0);
    if (bus.rvalid0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rvalid0_unexpected: got rvalid0 with rdata %0h, required none", bus.rdata);
      end else chk("rdata0", 32'(bus.rdata), 32'(q0.pop_front()));
    end
    if (bus.rvalid1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rvalid1_unexpected: got rvalid1 with rdata %0h, required none", bus.rdata);
      end else chk("rdata1", 32'(bus.rdata), 32'(q1.pop_front()));
    end
  endtask

  task automatic drive_req(input bit r, input bit on, input bit we,
                           input logic [7:0] a, input logic [7:0] d);
    if (!r) begin
      bus.req0 = on; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = on; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic do_txn(input txn_t t);
    int cycles = 0;
    int ce_cycles = 0;
    bit got = 1'b0;
    tick();
    drive_req(t.r, 1'b1, t.we, t.addr, t.wdata);
    stall_left = t.k;
    if (t.we) exp_mem[t.addr] = t.wdata;
    else if (t.r) begin q1.push_back(exp_mem[t.addr]); exp_stall1 += t.k; end
    else begin q0.push_back(exp_mem[t.addr]); exp_stall0 += t.k; end
    while (!got && cycles < 50) begin
      tick();
      cycles++;
      if (bus.m_ce) begin
        ce_cycles++;
        chk("m_addr_w", 32'(bus.m_addr_w), 32'(t.addr));
        chk("m_addr_r", 32'(bus.m_addr_r), 32'(t.addr));
        chk("m_we", 32'(bus.m_we), 32'(t.we));
        chk("m_oe", 32'(bus.m_oe), 32'(!t.we));
        if (t.we) chk("m_wdata", 32'(bus.m_wdata), 32'(t.wdata));
      end
      chk("ack_other", 32'(t.r ? bus.ack0 : bus.ack1), 0);
      got = t.r ? bus.ack1 : bus.ack0;
    end
    chk("ack_latency", cycles, t.we ? 1 : 2 + t.k);
    chk("ce_cycles", ce_cycles, t.we ? 1 : 1 + t.k);
    drive_req(t.r, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef SPRAM_ARB_STAT_EN
    chk("stall_cnt0", 32'(stall_cnt0), exp_stall0);
    chk("stall_cnt1", 32'(stall_cnt1), exp_stall1);
`endif
    $display("txn req%0d %s addr=%02h wdata=%02h stall=%0d latency=%0d",
             t.r, t.we ? "WR" : "RD", t.addr, t.wdata, t.k, cycles);
  endtask

  // Continuous reads from the enabled requesters until n grants are seen.
  task automatic run_cont(input bit en0, input bit en1, input int n);
    int seen = 0;
    int cycles = 0;
    int base = grant_log.size();
    tick();
    stall_left = 0;
    drive_req(1'b0, en0, 1'b0, 8'h10, 8'h00);
    drive_req(1'b1, en1, 1'b0, 8'h20, 8'h00);
    if (en0) q0.push_back(exp_mem[8'h10]);
    if (en1) q1.push_back(exp_mem[8'h20]);
    while (seen < n && cycles < 200) begin
      tick();
      cycles++;
      if (bus.ack0) begin seen++; if (seen < n) q0.push_back(exp_mem[8'h10]); end
      if (bus.ack1) begin seen++; if (seen < n) q1.push_back(exp_mem[8'h20]); end
    end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    q0.delete();
    q1.delete();
    chk("cont_grants", seen, n);
    for (int i = base; i < grant_log.size(); i++) begin
      if (en0 && en1) begin
        if (i > base) chk("grant_alternates", 32'(grant_log[i] != grant_log[i-1]), 1);
      end else chk("solo_grant_owner", grant_log[i], en1 ? 1 : 0);
    end
    $display("cont req0=%0b req1=%0b grants=%0d cycles=%0d", en0, en1, seen, cycles);
  endtask

  txn_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit got;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    rst = 1'b0;
    bus.m_valid = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    tbl[0] = '{0, 1, 8'h10, 8'hA5, 0};
    tbl[1] = '{0, 0, 8'h10, 8'h00, 0};
    tbl[2] = '{1, 1, 8'h20, 8'h3C, 0};
    tbl[3] = '{1, 0, 8'h20, 8'h00, 3};
    tbl[4] = '{0, 1, 8'hFF, 8'h5A, 0};
    tbl[5] = '{0, 0, 8'hFF, 8'h00, 1};
    tbl[6] = '{0, 0, 8'h20, 8'h00, 0};
    tbl[7] = '{1, 0, 8'h10, 8'h00, 2};
    tbl[8] = '{1, 1, 8'h00, 8'hFF, 0};
    tbl[9] = '{0, 0, 8'h00, 8'h00, 0};

    repeat (2) tick();
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    chk("rst_m_ctrl", 32'({bus.m_ce, bus.m_we, bus.m_oe}), 0);
    chk("rst_m_addr", 32'({bus.m_addr_w, bus.m_addr_r}), 0);
    chk("rst_m_wdata", 32'(bus.m_wdata), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);

    run_cont(1'b1, 1'b1, 8);
    run_cont(1'b1, 1'b0, 6);
    run_cont(1'b1, 1'b1, 6);

    // Reset while a read is stalled in WAIT.
    tick();
    drive_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    q1.push_back(exp_mem[8'h20]);
    stall_left = 20;
    cycles = 0;
    while (!bus.m_ce && cycles < 20) begin tick(); cycles++; end
    repeat (2) tick();
    chk("pre_reset_ce", 32'(bus.m_ce), 1);
    rst = 1'b0;
    q1.delete();
    #1;
    chk("reset_async_ctrl", 32'({bus.m_ce, bus.m_we, bus.m_oe}), 0);
    chk("reset_async_ack", 32'({bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1}), 0);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    stall_left = 0;
    bus.m_valid = 1'b1;
    exp_stall0 = 0;
    exp_stall1 = 0;
    repeat (2) tick();
    rst = 1'b1;
`ifdef SPRAM_ARB_STAT_EN
    chk("stall_cnt_cleared", 32'({stall_cnt0, stall_cnt1}), 0);
`endif
    drive_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    q0.push_back(exp_mem[8'h10]);
    q1.push_back(exp_mem[8'h20]);
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20) begin
      tick();
      cycles++;
      got = bus.ack0 | bus.ack1;
    end
    chk("post_reset_winner", 32'({bus.ack1, bus.ack0}), 32'b01);
    chk("post_reset_latency", cycles, 2);
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    q1.delete();
    repeat (3) tick();
    chk("final_scoreboard", q0.size() + q1.size(), 0);
    $display("reset-mid-wait sequence done, first grant after reset in %0d cycles", cycles);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spram_arb.md
Name: spram_arb

Overview:
- Two-requester arbiter and sequencer in front of one wait-state single-port SRAM (spram_wait-style: ce/we/oe, separate write/read address, ao_valid stall output).
- Serialises requests, holds the memory command stable across stall cycles, returns read data to the owning requester.
- Sits between the H.264 reconstruction and intra-prediction read clients and a shared line-buffer RAM.

Parameters:
- DW, 8, data width.
- AW, 8, address width.
- MAX_BURST, 4, max back-to-back grants to one requester while the other requests; range 1..15.

Ports:
- clk  in  1  clock, all logic rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- req0 / req1  in  1  request, held until ack
- we0 / we1  in  1  1=write, 0=read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle pulse, access accepted by memory
- rvalid0 / rvalid1  out  1  one-cycle pulse, rdata valid for that requester
- rdata  out  DW  registered read data, shared
- m_ce  out  1  memory chip enable
- m_we  out  1  memory write enable
- m_oe  out  1  memory output enable (reads)
- m_addr_w  out  AW  memory write address
- m_addr_r  out  AW  memory read address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- m_valid  in  1  memory ready/data valid; low = stall

Behaviour:
- Reset (rst=0, async): state IDLE; all ack/rvalid/m_ce/m_we/m_oe = 0; rdata, m_addr_*, m_wdata = 0; rr pointer = 0 (requester 0 preferred); burst count = 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req, arbitrate; latch winner id, we, addr, wdata into command registers; go ISSUE next cycle. No req: stay IDLE.
- Arbitration: only one requesting -> it wins. Both requesting -> rr pointer wins, unless burst count == MAX_BURST, then other wins. Winner == previous winner: burst count +1 (saturates); else reset to 1. After grant, rr pointer = other requester.
- ISSUE: drive m_ce=1, m_oe=~we, m_we=we, m_addr_w=m_addr_r=addr, m_wdata=wdata.
  - Write: completes this cycle regardless of m_valid; ack pulses in same cycle; next state IDLE.
  - Read with m_valid=1: rdata<=m_rdata; ack and rvalid of winner pulse next cycle; next state IDLE.
  - Read with m_valid=0: next state WAIT.
- WAIT: command outputs held unchanged, m_ce=1, m_oe=1. Stay until m_valid=1, then capture rdata, pulse ack+rvalid next cycle, go IDLE.
- Minimum access period 2 cycles (IDLE+ISSUE); no back-to-back issue.
- Requester deasserting req before ack: undefined; requesters must hold req/we/addr/wdata until ack.
- ack/rvalid never asserted to both requesters in the same cycle; rvalid only for reads.
- rdata holds last read value until next read completes.
- Reset mid-access: access dropped, no ack/rvalid produced, memory controls return to 0 immediately.

Optional Feature:
- Macro SPRAM_ARB_STAT_EN.
- Defined: adds outputs stall_cnt0/stall_cnt1 (16 bit each). Each counts WAIT-state cycles spent on that requester's reads; saturates at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single write: req0=1, we0=1, addr0=8'h10, wdata0=8'hA5 -> m_ce=m_we=1, m_addr_w=8'h10, m_wdata=8'hA5, ack0 pulse in the ISSUE cycle; later read of 8'h10 -> rdata=8'hA5, rvalid0=1.
- Stall: req1 read 8'h20 while memory holds m_valid=0 for 3 cycles -> m_ce/m_oe/m_addr_r held 3 cycles in WAIT; rvalid1 one cycle after m_valid rises; stall_cnt1=3 with SPRAM_ARB_STAT_EN.
- Fairness: req0 and req1 held continuously (reads, m_valid=1) -> grants alternate 0,1,0,1; never two ack in one cycle.
- Burst limit: MAX_BURST=2; req0 continuous, req1 continuous from the start -> grant order alternates. Also req0 continuous with req1 absent -> unlimited consecutive grants to 0.
- Reset mid-WAIT: rst driven 0 during WAIT -> m_ce=0 asynchronously; no rvalid; after release, first contention granted to requester 0.
